// File: rtl/tbl_req_responder_pkg.sv
// tbl_req_responder_pkg
//   Shared definitions for the table request responder: FSM state encoding
//   and a ceiling-log2 helper used to size row address ports.
package tbl_req_responder_pkg;

  localparam logic [1:0] ST_IDLE      = 2'b00;
  localparam logic [1:0] ST_ACK       = 2'b01;
  localparam logic [1:0] ST_WAIT_DROP = 2'b10;

  // Smallest r with 2**r >= n (n >= 2 in every use here).
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r = 0;
    while ((32'd1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/tbl_req_responder_reg_array.sv
// tbl_reg_array
//   Flop-based row storage, ROWS rows of ROW_W bits, all cleared by reset.
//   Ports:
//     clk_i, rst_ni        clock, async active-low reset
//     we_i/waddr_i/wdata_i single write port (out-of-range rows ignored)
//     rd_addr_i/rd_data_o  register-side read, combinational
//     lk_addr_i/lk_data_o  lookup-side read, combinational
//   Reads return the pre-edge contents, so a same-edge write is not visible
//   until the following cycle. Out-of-range reads return zero.
module tbl_reg_array #(
  parameter int ROWS  = 4,
  parameter int AW    = 2,
  parameter int ROW_W = 128
)(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [ROW_W-1:0] wdata_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [ROW_W-1:0] rd_data_o,
  input  logic [AW-1:0]    lk_addr_i,
  output logic [ROW_W-1:0] lk_data_o
);

  logic [ROWS-1:0][ROW_W-1:0] mem_q;

  // An address >= ROWS matches no row, so out-of-range writes fall through.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q <= '0;
    end else begin
      for (int r = 0; r < ROWS; r++) begin
        if (we_i && waddr_i == AW'(r)) mem_q[r] <= wdata_i;
      end
    end
  end

  always_comb begin
    rd_data_o = '0;
    if (int'(rd_addr_i) < ROWS) rd_data_o = mem_q[rd_addr_i];
  end

  always_comb begin
    lk_data_o = '0;
    if (int'(lk_addr_i) < ROWS) lk_data_o = mem_q[lk_addr_i];
  end

endmodule

// File: rtl/tbl_req_responder.sv
// tbl_req_responder
//   Row-wide register table with a req/ack handshake for bus-side reads and
//   writes, plus an optional single-cycle datapath lookup port.
//   Config macro: TBL_RESPONDER_LKUP_EN -- when defined, lkup_req/lkup_addr
//   exist and lookups are served; otherwise lkup_vld/lkup_data read zero.
//   Ports:
//     Bus2IP_Clk, Bus2IP_Resetn       clock, async active-low reset
//     tbl_rd_req/ack/addr/data         row read handshake (ack one cycle)
//     tbl_wr_req/ack/addr/data         row write handshake (ack one cycle)
//     lkup_req/addr (macro only)       lookup strobe and row
//     lkup_vld/lkup_data               lookup result, valid one cycle
//   Each handshake is acknowledged once; the initiator must drop its request
//   before another is accepted. Writes win when both requests are up.
module tbl_req_responder
  import tbl_req_responder_pkg::*;
#(
  parameter int  C_S_AXI_DATA_WIDTH = 32,
  parameter int  TBL_NUM_COLS       = 4,
  parameter int  TBL_NUM_ROWS       = 4,
  localparam int AW                 = int'(clog2(TBL_NUM_ROWS)),
  localparam int ROW_W              = C_S_AXI_DATA_WIDTH * TBL_NUM_COLS
)(
  input  logic             Bus2IP_Clk,
  input  logic             Bus2IP_Resetn,
  input  logic             tbl_rd_req,
  output logic             tbl_rd_ack,
  input  logic [AW-1:0]    tbl_rd_addr,
  output logic [ROW_W-1:0] tbl_rd_data,
  input  logic             tbl_wr_req,
  output logic             tbl_wr_ack,
  input  logic [AW-1:0]    tbl_wr_addr,
  input  logic [ROW_W-1:0] tbl_wr_data,
`ifdef TBL_RESPONDER_LKUP_EN
  input  logic             lkup_req,
  input  logic [AW-1:0]    lkup_addr,
`endif
  output logic             lkup_vld,
  output logic [ROW_W-1:0] lkup_data
);

  logic [1:0]       state_q, state_d;
  logic             rd_ack_q, rd_ack_d;
  logic             wr_ack_q, wr_ack_d;
  logic [ROW_W-1:0] rd_data_q, rd_data_d;
  logic             we;
  logic [ROW_W-1:0] arr_rd_data;
  logic [AW-1:0]    lk_addr;
  logic [ROW_W-1:0] lk_data;

  tbl_reg_array #(
    .ROWS  (TBL_NUM_ROWS),
    .AW    (AW),
    .ROW_W (ROW_W)
  ) u_arr (
    .clk_i     (Bus2IP_Clk),
    .rst_ni    (Bus2IP_Resetn),
    .we_i      (we),
    .waddr_i   (tbl_wr_addr),
    .wdata_i   (tbl_wr_data),
    .rd_addr_i (tbl_rd_addr),
    .rd_data_o (arr_rd_data),
    .lk_addr_i (lk_addr),
    .lk_data_o (lk_data)
  );

  // Requests are only looked at in IDLE; ACK always moves on, and WAIT_DROP
  // holds until the initiator releases both lines, which blocks re-acks.
  always_comb begin
    state_d   = state_q;
    rd_ack_d  = 1'b0;
    wr_ack_d  = 1'b0;
    rd_data_d = rd_data_q;
    we        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tbl_wr_req) begin
          we       = 1'b1;
          wr_ack_d = 1'b1;
          state_d  = ST_ACK;
        end else if (tbl_rd_req) begin
          rd_ack_d  = 1'b1;
          rd_data_d = arr_rd_data;
          state_d   = ST_ACK;
        end
      end
      ST_ACK:       state_d = ST_WAIT_DROP;
      ST_WAIT_DROP: if (!tbl_wr_req && !tbl_rd_req) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
    if (!Bus2IP_Resetn) begin
      state_q   <= ST_IDLE;
      rd_ack_q  <= 1'b0;
      wr_ack_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      rd_ack_q  <= rd_ack_d;
      wr_ack_q  <= wr_ack_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign tbl_rd_ack  = rd_ack_q;
  assign tbl_wr_ack  = wr_ack_q;
  assign tbl_rd_data = rd_data_q;

`ifdef TBL_RESPONDER_LKUP_EN
  logic             lkup_vld_q;
  logic [ROW_W-1:0] lkup_data_q;

  assign lk_addr = lkup_addr;

  // Lookup samples the array before the same-edge write lands, independent
  // of the handshake FSM. Data holds between strobes.
  always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
    if (!Bus2IP_Resetn) begin
      lkup_vld_q  <= 1'b0;
      lkup_data_q <= '0;
    end else begin
      lkup_vld_q <= lkup_req;
      if (lkup_req) lkup_data_q <= lk_data;
    end
  end

  assign lkup_vld  = lkup_vld_q;
  assign lkup_data = lkup_data_q;
`else
  // Lookup read port is parked on row 0 and its result masked off, so the
  // outputs are constant zero and the port logic trims away.
  assign lk_addr   = '0;
  assign lkup_vld  = 1'b0;
  assign lkup_data = lk_data & '0;
`endif

endmodule

// File: tb/tb_tbl_req_responder.sv
// tb_tbl_req_responder
//   Randomized and directed bench for tbl_req_responder. Two instances share
//   clock and reset: [0] with 4 rows, [1] with 3 rows (row 3 out of range).
//   A plain array of rows is the reference table.
module tb_tbl_req_responder;

  localparam int W  = 128;
  localparam int AW = 2;

  logic                  clk, rst_n;
  logic [1:0]            wr_req, rd_req, wr_ack, rd_ack, lk_vld;
  logic [1:0][AW-1:0]    wr_addr, rd_addr;
  logic [1:0][W-1:0]     wr_data, rd_data, lk_data;
`ifdef TBL_RESPONDER_LKUP_EN
  logic [1:0]            lk_req;
  logic [1:0][AW-1:0]    lk_addr;
`endif

  logic [W-1:0] mdl [2][4];
  int n_cmp = 0;
  int n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  tbl_req_responder #(.TBL_NUM_ROWS(4)) u_dut4 (
    .Bus2IP_Clk(clk), .Bus2IP_Resetn(rst_n),
    .tbl_rd_req(rd_req[0]), .tbl_rd_ack(rd_ack[0]), .tbl_rd_addr(rd_addr[0]), .tbl_rd_data(rd_data[0]),
    .tbl_wr_req(wr_req[0]), .tbl_wr_ack(wr_ack[0]), .tbl_wr_addr(wr_addr[0]), .tbl_wr_data(wr_data[0]),
`ifdef TBL_RESPONDER_LKUP_EN
    .lkup_req(lk_req[0]), .lkup_addr(lk_addr[0]),
`endif
    .lkup_vld(lk_vld[0]), .lkup_data(lk_data[0])
  );

  tbl_req_responder #(.TBL_NUM_ROWS(3)) u_dut3 (
    .Bus2IP_Clk(clk), .Bus2IP_Resetn(rst_n),
    .tbl_rd_req(rd_req[1]), .tbl_rd_ack(rd_ack[1]), .tbl_rd_addr(rd_addr[1]), .tbl_rd_data(rd_data[1]),
    .tbl_wr_req(wr_req[1]), .tbl_wr_ack(wr_ack[1]), .tbl_wr_addr(wr_addr[1]), .tbl_wr_data(wr_data[1]),
`ifdef TBL_RESPONDER_LKUP_EN
    .lkup_req(lk_req[1]), .lkup_addr(lk_addr[1]),
`endif
    .lkup_vld(lk_vld[1]), .lkup_data(lk_data[1])
  );

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic int nrows(input int sel);
    return (sel == 1) ? 3 : 4;
  endfunction

  function automatic logic [W-1:0] mdl_rd(input int sel, input int addr);
    return (addr < nrows(sel)) ? mdl[sel][addr] : '0;
  endfunction

  function automatic logic [W-1:0] rnd_row();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic clr_mdl();
    for (int s = 0; s < 2; s++)
      for (int r = 0; r < 4; r++) mdl[s][r] = '0;
  endtask

  // One handshake from IDLE: raise, expect ack one edge later, keep the
  // request up for 'hold' extra cycles (no re-ack, data stable), drop, and
  // let the responder get back to IDLE. Called just after a falling edge.
  task automatic xact(input int sel, input bit is_wr, input int addr,
                      input logic [W-1:0] wdata, input int hold);
    int cyc;
    logic [W-1:0] exp;
    string nm;
    nm  = is_wr ? "wr" : "rd";
    exp = mdl_rd(sel, addr);
    if (is_wr) begin
      wr_addr[sel] = AW'(addr); wr_data[sel] = wdata; wr_req[sel] = 1'b1;
    end else begin
      rd_addr[sel] = AW'(addr); rd_req[sel] = 1'b1;
    end
    cyc = 0;
    do begin
      @(negedge clk); cyc++;
    end while (!(is_wr ? wr_ack[sel] : rd_ack[sel]) && cyc < 10);
    chk({nm, "_latency"}, W'(cyc), W'(1));
    chk({nm, "_other_ack"}, W'(is_wr ? rd_ack[sel] : wr_ack[sel]), '0);
    if (is_wr) begin
      if (addr < nrows(sel)) mdl[sel][addr] = wdata;
    end else begin
      chk("rd_data", rd_data[sel], exp);
    end
    for (int i = 0; i <= hold; i++) begin
      @(negedge clk);
      chk({nm, "_no_reack"}, W'(is_wr ? wr_ack[sel] : rd_ack[sel]), '0);
    end
    if (!is_wr) chk("rd_data_hold", rd_data[sel], exp);
    wr_req[sel] = 1'b0; rd_req[sel] = 1'b0;
    @(negedge clk); @(negedge clk);
  endtask

  initial begin
    logic [W-1:0] d, old, aa;
    rst_n = 1'b0;
    wr_req = '0; rd_req = '0; wr_addr = '0; rd_addr = '0; wr_data = '0;
`ifdef TBL_RESPONDER_LKUP_EN
    lk_req = '0; lk_addr = '0;
`endif
    clr_mdl();

    // Reset state
    #1;
    chk("rst_acks", W'({rd_ack, wr_ack}), '0);
    chk("rst_rd_data0", rd_data[0], '0);
    chk("rst_rd_data1", rd_data[1], '0);
    chk("rst_lk", W'(lk_vld), '0);
    chk("rst_lk_data", lk_data[0] | lk_data[1], '0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Write row 2 then read it back
    xact(0, 1'b1, 2, {32'h44, 32'h33, 32'h22, 32'h11}, 0);
    xact(0, 1'b0, 2, '0, 0);
    chk("wr_rd_row2", rd_data[0], 128'h00000044_00000033_00000022_00000011);

    // Held read: a single ack over five extra cycles
    xact(0, 1'b0, 2, '0, 5);

    // Simultaneous requests: write first, read only after a fresh raise
    d = rnd_row();
    wr_addr[0] = 2'd1; wr_data[0] = d; rd_addr[0] = 2'd1;
    wr_req[0] = 1'b1; rd_req[0] = 1'b1;
    @(negedge clk);
    chk("sim_wr_ack", W'(wr_ack[0]), W'(1));
    chk("sim_rd_ack_blocked", W'(rd_ack[0]), '0);
    mdl[0][1] = d;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("sim_no_ack", W'({wr_ack[0], rd_ack[0]}), '0);
    end
    wr_req[0] = 1'b0; rd_req[0] = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("sim_idle_no_ack", W'({wr_ack[0], rd_ack[0]}), '0);
    xact(0, 1'b0, 1, '0, 0);
    chk("sim_new_data", rd_data[0], d);

    // Out-of-range row on the 3-row instance
    d = rnd_row();
    xact(1, 1'b1, 2, d, 0);
    xact(1, 1'b1, 3, rnd_row(), 1);
    xact(1, 1'b0, 3, '0, 1);
    chk("oor_rd_zero", rd_data[1], '0);
    xact(1, 1'b0, 2, '0, 0);
    chk("oor_row2_kept", rd_data[1], d);

`ifdef TBL_RESPONDER_LKUP_EN
    // Lookup colliding with a write to the same row sees the old contents
    old = mdl[0][0];
    aa  = {4{32'hAAAAAAAA}};
    wr_addr[0] = 2'd0; wr_data[0] = aa; wr_req[0] = 1'b1;
    lk_addr[0] = 2'd0; lk_req[0] = 1'b1;
    @(negedge clk);
    chk("lk_vld", W'(lk_vld[0]), W'(1));
    chk("lk_rbw_old", lk_data[0], old);
    chk("lk_wr_ack", W'(wr_ack[0]), W'(1));
    mdl[0][0] = aa;
    wr_req[0] = 1'b0;
    @(negedge clk);
    chk("lk_vld2", W'(lk_vld[0]), W'(1));
    chk("lk_new", lk_data[0], aa);
    lk_req[0] = 1'b0;
    @(negedge clk);
    chk("lk_vld_drop", W'(lk_vld[0]), '0);
    @(negedge clk);
`else
    aa = '0; old = aa;
`endif

    // Random register traffic against the reference table
    for (int n = 0; n < 50; n++) begin
      xact($urandom_range(0, 1), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
           rnd_row(), $urandom_range(0, 3));
`ifndef TBL_RESPONDER_LKUP_EN
      chk("lk_tied", W'(lk_vld) | lk_data[0] | lk_data[1], '0);
`endif
    end

`ifdef TBL_RESPONDER_LKUP_EN
    // Random lookups, both instances, including the out-of-range row
    for (int n = 0; n < 40; n++) begin
      int a0, a1;
      logic [1:0] rq;
      rq = 2'($urandom_range(0, 3));
      a0 = $urandom_range(0, 3); a1 = $urandom_range(0, 3);
      lk_req = rq; lk_addr[0] = AW'(a0); lk_addr[1] = AW'(a1);
      @(negedge clk);
      chk("lk_rnd_vld", W'(lk_vld), W'(rq));
      if (rq[0]) chk("lk_rnd_data0", lk_data[0], mdl_rd(0, a0));
      if (rq[1]) chk("lk_rnd_data1", lk_data[1], mdl_rd(1, a1));
    end
    lk_req = '0;
    @(negedge clk);
`endif

    // Reset asserted while the read ack is high; request survives reset
    xact(0, 1'b1, 2, {4{32'h5A5A_0F0F}}, 0);
    rd_addr[0] = 2'd2; rd_req[0] = 1'b1;
    @(negedge clk);
    chk("rst_pre_ack", W'(rd_ack[0]), W'(1));
    chk("rst_pre_data", rd_data[0], mdl[0][2]);
    rst_n = 1'b0;
    #1;
    chk("rst_ack_drop", W'(rd_ack[0]), '0);
    chk("rst_data_drop", rd_data[0], '0);
    chk("rst_lk_drop", W'(lk_vld) | lk_data[0] | lk_data[1], '0);
    clr_mdl();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_reaccept", W'(rd_ack[0]), W'(1));
    chk("rst_cells_zero", rd_data[0], '0);
    rd_req[0] = 1'b0;
    @(negedge clk); @(negedge clk);
    for (int r = 0; r < 4; r++) xact(0, 1'b0, r, '0, 0);
    for (int r = 0; r < 3; r++) xact(1, 1'b0, r, '0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Cycle budget guard
  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
